cnf_host_loader: RTL and testbench

- Host-side front end feeding the solver top level's CNF load port and start/result pins.
- Accepts a DIMACS-style word stream: signed 32-bit literals, with 0 terminating each clause.
- Converts the stream to literal + clause_end beats, validates it against core capacity, then pulses start and supervises the solve with a cycle counter and optional timeout.
- Latches the result for the host.

---
 rtl/cnf_host_loader.sv | 267 ++++++++++++++++++++++++++
 tb/tb_cnf_host_loader.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnf_host_loader.sv
// cnf_host_loader: host front end for the solver CNF load port.
// Turns a DIMACS-style word stream (signed literals, 0 ends a clause) into
// literal/clause_end beats, checks the load against core capacity, then
// pulses start and supervises the solve with a cycle counter and timeout.
module cnf_host_loader #(
  parameter int MAX_VARS    = 256,
  parameter int MAX_CLAUSES = 256,
  parameter int MAX_LITS    = 2048,
  parameter int CYC_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [CYC_W-1:0] timeout_cycles,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic             host_load_valid,
  output logic [31:0]      host_load_literal,
  output logic             host_load_clause_end,
  input  logic             host_load_ready,
  output logic             host_start,
  input  logic             host_done,
  input  logic             host_sat,
  input  logic             host_unsat,
  output logic             busy,
  output logic             result_valid,
  output logic             result_sat,
  output logic             result_unsat,
  output logic             result_timeout,
  output logic [2:0]       err_code,
  output logic [15:0]      num_clauses,
  output logic [15:0]      num_lits,
  output logic [CYC_W-1:0] cycle_count
);

  localparam logic [31:0]      MAX_VARS_W    = 32'(MAX_VARS);
  localparam logic [15:0]      MAX_CLAUSES_W = 16'(MAX_CLAUSES);
  localparam logic [15:0]      MAX_LITS_W    = 16'(MAX_LITS);
  localparam logic [CYC_W-1:0] CYC_ZERO      = {CYC_W{1'b0}};
  localparam logic [CYC_W-1:0] CYC_ONE       = {{(CYC_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0] CYC_MAX       = {CYC_W{1'b1}};

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_BAD_LIT    = 3'd1;
  localparam logic [2:0] ERR_EMPTY      = 3'd2;
  localparam logic [2:0] ERR_CLAUSE_OVF = 3'd3;
  localparam logic [2:0] ERR_LIT_OVF    = 3'd4;
  localparam logic [2:0] ERR_UNTERM     = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_START = 3'd3,
    ST_SOLVE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  // Magnitude of a two's complement literal (0x80000000 maps to itself).
  function automatic logic [31:0] lit_mag(input logic [31:0] w);
    lit_mag = w[31] ? (32'd0 - w) : w;
  endfunction

  state_t           state_r, state_n;
  logic             p_valid_r;
  logic [31:0]      p_lit_r;
  logic             o_valid_r;
  logic [31:0]      o_lit_r;
  logic             o_ce_r;
  logic [15:0]      num_clauses_r, num_lits_r;
  logic [CYC_W-1:0] cycle_count_r;
  logic             res_sat_r, res_unsat_r, res_to_r;
  logic [2:0]       err_code_r;
  logic             busy_r, host_start_r, result_valid_r;

  logic             s_ready_s, accept_s, o_take_s, word_zero_s;
  logic [2:0]       word_err_s;
  logic             load_err_s, timeout_hit_s, go_take_s;

  // Handshakes and per-word validation; lowest error code has priority.
  always_comb begin
    s_ready_s   = (state_r == ST_LOAD) && (!o_valid_r || host_load_ready);
    accept_s    = s_valid && s_ready_s;
    o_take_s    = o_valid_r && host_load_ready;
    word_zero_s = (s_data == 32'd0);
    if (!word_zero_s && ((s_data == 32'h8000_0000) || (lit_mag(s_data) > MAX_VARS_W))) begin
      word_err_s = ERR_BAD_LIT;
    end else if (word_zero_s && !p_valid_r) begin
      word_err_s = ERR_EMPTY;
    end else if (word_zero_s && (num_clauses_r >= MAX_CLAUSES_W)) begin
      word_err_s = ERR_CLAUSE_OVF;
    end else if (!word_zero_s && (num_lits_r >= MAX_LITS_W)) begin
      word_err_s = ERR_LIT_OVF;
    end else if (!word_zero_s && s_last) begin
      word_err_s = ERR_UNTERM;
    end else begin
      word_err_s = ERR_NONE;
    end
    load_err_s    = accept_s && (word_err_s != ERR_NONE);
    timeout_hit_s = (timeout_cycles != CYC_ZERO) &&
                    (cycle_count_r == (timeout_cycles - CYC_ONE));
  end

  // Next-state logic for the load/solve sequence.
  always_comb begin
    state_n   = state_r;
    go_take_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (go) begin
          go_take_s = 1'b1;
          state_n   = ST_LOAD;
        end else begin
          state_n   = state_r;
        end
      end
      ST_LOAD: begin
        if (load_err_s) begin
          state_n = ST_ERROR;
        end else if (accept_s && s_last) begin
          state_n = ST_DRAIN;
        end else begin
          state_n = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (!o_valid_r) begin
          state_n = ST_START;
        end else begin
          state_n = ST_DRAIN;
        end
      end
      ST_START: state_n = ST_SOLVE;
      ST_SOLVE: begin
        if (host_done || timeout_hit_s) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_SOLVE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Literal pipeline (P -> O), load counters, solve counter and results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_r     <= 1'b0;
      p_lit_r       <= 32'd0;
      o_valid_r     <= 1'b0;
      o_lit_r       <= 32'd0;
      o_ce_r        <= 1'b0;
      num_clauses_r <= 16'd0;
      num_lits_r    <= 16'd0;
      cycle_count_r <= CYC_ZERO;
      res_sat_r     <= 1'b0;
      res_unsat_r   <= 1'b0;
      res_to_r      <= 1'b0;
      err_code_r    <= ERR_NONE;
    end else if (go_take_s) begin
      p_valid_r     <= 1'b0;
      o_valid_r     <= 1'b0;
      num_clauses_r <= 16'd0;
      num_lits_r    <= 16'd0;
      cycle_count_r <= CYC_ZERO;
      res_sat_r     <= 1'b0;
      res_unsat_r   <= 1'b0;
      res_to_r      <= 1'b0;
      err_code_r    <= ERR_NONE;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (load_err_s) begin
            // Partial load is abandoned; nothing more reaches the cores.
            p_valid_r  <= 1'b0;
            o_valid_r  <= 1'b0;
            err_code_r <= word_err_s;
          end else begin
            if (o_take_s) begin
              o_valid_r <= 1'b0;
            end
            if (accept_s) begin
              if (word_zero_s) begin
                o_valid_r     <= 1'b1;
                o_lit_r       <= p_lit_r;
                o_ce_r        <= 1'b1;
                p_valid_r     <= 1'b0;
                num_clauses_r <= num_clauses_r + 16'd1;
              end else begin
                if (p_valid_r) begin
                  o_valid_r <= 1'b1;
                  o_lit_r   <= p_lit_r;
                  o_ce_r    <= 1'b0;
                end
                p_valid_r  <= 1'b1;
                p_lit_r    <= s_data;
                num_lits_r <= num_lits_r + 16'd1;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (o_take_s) begin
            o_valid_r <= 1'b0;
          end
        end
        ST_START: cycle_count_r <= CYC_ZERO;
        ST_SOLVE: begin
          if (host_done) begin
            res_sat_r   <= host_sat;
            res_unsat_r <= host_unsat;
            res_to_r    <= 1'b0;
          end else if (timeout_hit_s) begin
            res_to_r    <= 1'b1;
          end else if (cycle_count_r != CYC_MAX) begin
            cycle_count_r <= cycle_count_r + CYC_ONE;
          end
        end
        default: begin
          p_valid_r <= p_valid_r;
        end
      endcase
    end
  end

  // Status outputs registered from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r         <= 1'b0;
      host_start_r   <= 1'b0;
      result_valid_r <= 1'b0;
    end else begin
      busy_r         <= (state_n == ST_LOAD) || (state_n == ST_DRAIN) ||
                        (state_n == ST_START) || (state_n == ST_SOLVE);
      host_start_r   <= (state_n == ST_START);
      result_valid_r <= (state_n == ST_DONE);
    end
  end

  assign s_ready              = s_ready_s;
  assign host_load_valid      = o_valid_r;
  assign host_load_literal    = o_lit_r;
  assign host_load_clause_end = o_ce_r;
  assign host_start           = host_start_r;
  assign busy                 = busy_r;
  assign result_valid         = result_valid_r;
  assign result_sat           = res_sat_r;
  assign result_unsat         = res_unsat_r;
  assign result_timeout       = res_to_r;
  assign err_code             = err_code_r;
  assign num_clauses          = num_clauses_r;
  assign num_lits             = num_lits_r;
  assign cycle_count          = cycle_count_r;

endmodule

// File: tb/tb_cnf_host_loader.sv
// tb_cnf_host_loader: randomized and directed loads/solves of cnf_host_loader
// compared against a word-level reference model of the load rules.
module tb_cnf_host_loader;
  localparam int MAX_VARS    = 256;
  localparam int MAX_CLAUSES = 256;
  localparam int MAX_LITS    = 2048;
  localparam int CYC_W       = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             go = 1'b0;
  logic [CYC_W-1:0] timeout_cycles = '0;
  logic             s_valid = 1'b0;
  logic [31:0]      s_data = 32'd0;
  logic             s_last = 1'b0;
  logic             s_ready;
  logic             host_load_valid;
  logic [31:0]      host_load_literal;
  logic             host_load_clause_end;
  logic             host_load_ready = 1'b1;
  logic             host_start;
  logic             host_done = 1'b0;
  logic             host_sat = 1'b0;
  logic             host_unsat = 1'b0;
  logic             busy, result_valid, result_sat, result_unsat, result_timeout;
  logic [2:0]       err_code;
  logic [15:0]      num_clauses, num_lits;
  logic [CYC_W-1:0] cycle_count;

  cnf_host_loader #(
    .MAX_VARS(MAX_VARS), .MAX_CLAUSES(MAX_CLAUSES), .MAX_LITS(MAX_LITS), .CYC_W(CYC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .timeout_cycles(timeout_cycles),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .host_load_valid(host_load_valid), .host_load_literal(host_load_literal),
    .host_load_clause_end(host_load_clause_end), .host_load_ready(host_load_ready),
    .host_start(host_start), .host_done(host_done), .host_sat(host_sat),
    .host_unsat(host_unsat), .busy(busy), .result_valid(result_valid),
    .result_sat(result_sat), .result_unsat(result_unsat),
    .result_timeout(result_timeout), .err_code(err_code),
    .num_clauses(num_clauses), .num_lits(num_lits), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;
  int rdy_mode = 0;
  int rdy_cnt  = 0;

  logic [31:0] w_arr[$];
  bit          l_arr[$];
  logic [32:0] exp_q[$];   // {clause_end, literal}
  int          m_err, m_err_idx, m_nc, m_nl;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_eq(input string name, input longint act, input longint exp);
    chk(act == exp, name, act, exp);
  endtask

  task automatic add(input int v, input bit last);
    w_arr.push_back(32'(v));
    l_arr.push_back(last);
  endtask

  // Reference model: walk the words, find the first error, counts, and beats.
  task automatic model_run();
    int nl, nc, code, lim;
    bit pend;
    longint av;
    int sw;
    exp_q.delete();
    nl = 0; nc = 0; pend = 0; m_err = 0; m_err_idx = -1;
    for (int i = 0; i < w_arr.size(); i++) begin
      sw = int'(w_arr[i]);
      av = (sw < 0) ? -longint'(sw) : longint'(sw);
      code = 0;
      if (sw != 0 && (w_arr[i] == 32'h8000_0000 || av > MAX_VARS)) code = 1;
      else if (sw == 0 && !pend) code = 2;
      else if (sw == 0 && nc >= MAX_CLAUSES) code = 3;
      else if (sw != 0 && nl >= MAX_LITS) code = 4;
      else if (sw != 0 && l_arr[i]) code = 5;
      if (code != 0) begin
        m_err = code; m_err_idx = i;
        break;
      end
      if (sw == 0) begin nc++; pend = 0; end
      else begin nl++; pend = 1; end
    end
    m_nc = nc; m_nl = nl;
    lim = (m_err_idx < 0) ? w_arr.size() : m_err_idx;
    // A literal is emitted once the next word is accepted without error.
    for (int i = 0; i + 1 < lim; i++)
      if (w_arr[i] != 32'd0) exp_q.push_back({(w_arr[i+1] == 32'd0), w_arr[i]});
  endtask

  // Ready pattern for the solver side: always, 1-of-3, or random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: host_load_ready = 1'b1;
      1: host_load_ready = (rdy_cnt % 3 == 0);
      default: host_load_ready = 1'($urandom_range(0, 1));
    endcase
    rdy_cnt++;
  end

  // Compare process: beats vs model, O stability under stall, s_ready rule.
  bit          prev_stall = 0;
  logic [31:0] prev_lit;
  logic        prev_ce;
  always @(negedge clk) begin
    if (host_start) start_cnt++;
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        if (host_load_valid)
          chk(host_load_literal == prev_lit && host_load_clause_end == prev_ce,
              "o_stable", longint'(host_load_literal), longint'(prev_lit));
        else
          chk(err_code != 3'd0, "o_dropped_in_stall", err_code, 1);
      end
      if (s_ready)
        chk(!(host_load_valid && !host_load_ready), "s_ready_when_full", host_load_ready, 1);
      if (err_code != 3'd0)
        chk(!result_valid, "result_valid_in_error", result_valid, 0);
      if (host_load_valid && host_load_ready) begin
        if (exp_q.size() == 0) begin
          chk(0, "beat_extra", longint'($signed(host_load_literal)), 0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk_eq("beat_literal", longint'($signed(host_load_literal)), longint'($signed(e[31:0])));
          chk_eq("beat_clause_end", host_load_clause_end, e[32]);
        end
      end
      prev_stall = host_load_valid && !host_load_ready;
      prev_lit   = host_load_literal;
      prev_ce    = host_load_clause_end;
    end
  end

  task automatic pulse_go();
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
  endtask

  task automatic send_word(input int i, output bit ok);
    s_valid = 1'b1; s_data = w_arr[i]; s_last = l_arr[i];
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (s_ready) ok = 1;
      @(posedge clk); #1;
      if (ok) break;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk_eq({tag, "_outputs"}, {host_load_valid, host_start, busy, result_valid,
            result_sat, result_unsat, result_timeout, s_ready}, 0);
    chk_eq({tag, "_err_code"}, err_code, 0);
    chk_eq({tag, "_counts"}, {num_clauses, num_lits}, 0);
    chk_eq({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  // One complete go/load/solve pass over w_arr/l_arr.
  task automatic run_load(input int rmode, input logic [CYC_W-1:0] tmo, input int done_at,
                          input bit sat, input bit go_mid, input bit do_rst);
    int nsend, sc;
    bit ok, got;
    longint e_cc;
    model_run();
    rdy_mode = rmode;
    timeout_cycles = tmo;
    start_cnt = 0;
    pulse_go();
    chk_eq("after_go_busy", busy, 1);
    chk_eq("after_go_clear", {err_code, result_valid, num_lits, num_clauses}, 0);
    nsend = (m_err_idx < 0) ? w_arr.size() : m_err_idx + 1;
    for (int i = 0; i < nsend; i++) begin
      if (go_mid && i == nsend / 2) begin
        s_valid = 1'b0;
        pulse_go();
      end
      send_word(i, ok);
      if (!ok) begin
        chk(0, "accept_timeout", i, nsend);
        break;
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (m_err == 0) begin
      got = 0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        if (host_start) begin got = 1; break; end
      end
      chk(got, "start_seen", got, 1);
      chk_eq("beats_left", exp_q.size(), 0);
      chk_eq("num_clauses", num_clauses, m_nc);
      chk_eq("num_lits", num_lits, m_nl);
      if (do_rst) begin
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        sc = start_cnt;
        repeat (4) @(negedge clk);
        chk_eq("no_start_after_reset", start_cnt, sc);
        check_all_zero("reset_held");
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
      got = 0;
      for (int j = 0; j < 2000; j++) begin
        @(posedge clk); #1;
        host_done  = (done_at >= 0 && j >= done_at);
        host_sat   = host_done & sat;
        host_unsat = host_done & !sat;
        @(negedge clk);
        if (j == 1) chk_eq("solve_busy", busy, 1);
        if (result_valid) begin got = 1; break; end
      end
      @(posedge clk); #1;
      host_done = 1'b0; host_sat = 1'b0; host_unsat = 1'b0;
      chk(got, "result_seen", got, 1);
      if (done_at >= 0 && (tmo == 0 || longint'(done_at) <= longint'(tmo) - 1)) begin
        chk_eq("result_sat", result_sat, sat);
        chk_eq("result_unsat", result_unsat, !sat);
        chk_eq("result_timeout", result_timeout, 0);
        e_cc = done_at;
      end else begin
        chk_eq("result_sat_to", {result_sat, result_unsat}, 0);
        chk_eq("result_timeout", result_timeout, 1);
        e_cc = longint'(tmo) - 1;
      end
      chk_eq("cycle_count", cycle_count, e_cc);
      repeat (3) @(negedge clk);
      chk_eq("done_held", {result_valid, busy, err_code}, {1'b1, 1'b0, 3'd0});
      chk_eq("cycle_count_held", cycle_count, e_cc);
      chk_eq("start_once", start_cnt, 1);
    end else begin
      repeat (3) @(negedge clk);
      chk_eq("err_code", err_code, m_err);
      chk_eq("err_outputs", {host_load_valid, result_valid, busy}, 0);
      chk_eq("err_no_start", start_cnt, 0);
      chk_eq("err_num_clauses", num_clauses, m_nc);
      chk_eq("err_num_lits", num_lits, m_nl);
      @(posedge clk); #1;
    end
  endtask

  task automatic gen_random();
    int nc, len, v, j, kind;
    int cand[$];
    w_arr.delete(); l_arr.delete();
    nc = $urandom_range(1, 6);
    for (int c = 0; c < nc; c++) begin
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        v = $urandom_range(1, MAX_VARS);
        if ($urandom_range(0, 1) == 1) v = -v;
        add(v, 0);
      end
      add(0, c == nc - 1);
    end
    kind = $urandom_range(0, 5);
    j = $urandom_range(0, w_arr.size() - 1);
    while (w_arr[j] == 32'd0) j--;
    case (kind)
      3: begin
        if ($urandom_range(0, 1) == 1) w_arr[j] = 32'h8000_0000;
        else begin
          v = MAX_VARS + 1 + $urandom_range(0, 500);
          w_arr[j] = ($urandom_range(0, 1) == 1) ? 32'(v) : 32'(-v);
        end
      end
      4: begin
        cand.push_back(0);
        for (int i = 0; i + 1 < w_arr.size(); i++)
          if (w_arr[i] == 32'd0) cand.push_back(i + 1);
        j = cand[$urandom_range(0, cand.size() - 1)];
        w_arr.insert(j, 32'd0);
        l_arr.insert(j, 1'b0);
      end
      5: begin
        while (w_arr.size() > j + 1) begin
          void'(w_arr.pop_back());
          void'(l_arr.pop_back());
        end
        l_arr[j] = 1'b1;
      end
      default: ;
    endcase
  endtask

  initial begin
    logic [CYC_W-1:0] tmo;
    int done_at;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;

    // Basic stream [1,-2,0,3,0]; pin the model with literal expectations.
    w_arr.delete(); l_arr.delete();
    add(1, 0); add(-2, 0); add(0, 0); add(3, 0); add(0, 1);
    model_run();
    chk_eq("model_beats", exp_q.size(), 3);
    chk_eq("model_beat0", exp_q[0], {1'b0, 32'd1});
    chk_eq("model_beat1", exp_q[1], {1'b1, 32'hFFFF_FFFE});
    chk_eq("model_beat2", exp_q[2], {1'b1, 32'd3});
    chk_eq("model_counts", {m_err, m_nc, m_nl}, {32'd0, 32'd2, 32'd3});
    run_load(0, 32'd0, 5, 1'b1, 0, 0);
    run_load(1, 32'd100, -1, 1'b0, 0, 0);
    run_load(2, 32'd100, 99, 1'b1, 0, 0);

    // Empty clause.
    w_arr.delete(); l_arr.delete();
    add(5, 0); add(0, 0); add(0, 1);
    model_run();
    chk_eq("model_empty", {m_err, m_err_idx}, {32'd2, 32'd2});
    run_load(1, 32'd0, 0, 1'b0, 0, 0);

    // Literal out of range, most-negative word, unterminated last clause.
    w_arr.delete(); l_arr.delete();
    add(257, 0); add(0, 1);
    model_run();
    chk_eq("model_bad_lit", m_err, 1);
    run_load(0, 32'd0, 0, 1'b0, 0, 0);
    w_arr.delete(); l_arr.delete();
    add(-256, 0); add(0, 0); add(int'(32'h8000_0000), 0); add(0, 1);
    run_load(0, 32'd0, 0, 1'b0, 0, 0);
    w_arr.delete(); l_arr.delete();
    add(4, 1);
    model_run();
    chk_eq("model_unterm", m_err, 5);
    run_load(0, 32'd0, 0, 1'b0, 0, 0);

    // Clause capacity: 257 single-literal clauses.
    w_arr.delete(); l_arr.delete();
    for (int i = 0; i < MAX_CLAUSES + 1; i++) begin add(i % MAX_VARS + 1, 0); add(0, i == MAX_CLAUSES); end
    model_run();
    chk_eq("model_clause_ovf", {m_err, m_err_idx, m_nc}, {32'd3, 32'd513, 32'd256});
    run_load(0, 32'd0, 0, 1'b0, 0, 0);

    // Literal capacity: one clause of MAX_LITS+1 literals.
    w_arr.delete(); l_arr.delete();
    for (int i = 0; i < MAX_LITS + 1; i++) add(-7, 0);
    add(0, 1);
    model_run();
    chk_eq("model_lit_ovf", {m_err, m_nl}, {32'd4, 32'd2048});
    run_load(0, 32'd0, 0, 1'b0, 0, 0);

    // Randomized streams, ready patterns and solve outcomes.
    for (int it = 0; it < 30; it++) begin
      gen_random();
      tmo = ($urandom_range(0, 1) == 1) ? 32'd0 : 32'($urandom_range(1, 40));
      done_at = (tmo == 0 || $urandom_range(0, 1) == 1) ? $urandom_range(0, 50) : -1;
      run_load($urandom_range(0, 2), tmo, done_at, 1'($urandom_range(0, 1)), 0, 0);
    end

    // Reset during SOLVE, then a clean load with a stray go during LOAD.
    w_arr.delete(); l_arr.delete();
    add(2, 0); add(0, 0); add(-9, 0); add(10, 0); add(0, 1);
    run_load(0, 32'd0, -1, 1'b0, 0, 1);
    w_arr.delete(); l_arr.delete();
    add(11, 0); add(12, 0); add(0, 0); add(-13, 0); add(0, 0); add(14, 0); add(0, 1);
    run_load(2, 32'd0, 3, 1'b0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case anything above stops making progress.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected %0d", n_checks, 0);
    $fatal(1, "global timeout");
  end

endmodule
